// File: rtl/crc_engine_param_if.sv
// TinyQV peripheral bus bundle for the CRC engine.
interface crc_engine_param_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt
  );
endinterface

// File: rtl/crc_engine_param.sv
// Parametrised CRC-8..32 engine: word FIFO in front of a bit-serial
// (1/2/4/8 bits per clock) LFSR with programmable poly/init/reflect/xor.
module crc_engine_param #(
  parameter int          CRC_W          = 32,
  parameter int          FIFO_DEPTH     = 4,
  parameter int          BITS_PER_CYCLE = 1,
  parameter logic [31:0] POLY_RST       = 32'h04C11DB7
) (
  input logic               clk,
  input logic               rst_n,
  crc_engine_param_if.slave bus
);
  localparam int               AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0]      DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0]       BPC     = 4'(BITS_PER_CYCLE);
  localparam logic [2:0]       LAST_BI = 3'(8 - BITS_PER_CYCLE);
  localparam logic [CRC_W-1:0] ONES    = '1;

  localparam logic [5:0] A_CTRL = 6'h00, A_STATUS = 6'h04, A_DATA = 6'h08,
                         A_RESULT = 6'h0C, A_POLY = 6'h10, A_INIT = 6'h14,
                         A_XOR = 6'h18;
  localparam int EN = 0, REFIN = 1, REFOUT = 2, XOREN = 3, IRQEN = 4;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [4:0]       ctrl_q, ctrl_d;
  logic             ovf_q, ovf_d, done_q, done_d, push_prev_q, push_prev_d;
  logic [CRC_W-1:0] crc_q, crc_d, poly_q, poly_d, init_q, init_d, xorval_q, xorval_d;
  logic [31:0]      fifo_data_q [FIFO_DEPTH];
  logic [31:0]      fifo_data_d [FIFO_DEPTH];
  logic [2:0]       fifo_nb_q [FIFO_DEPTH];
  logic [2:0]       fifo_nb_d [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [31:0]      word_q, word_d;
  logic [2:0]       nbytes_q, nbytes_d, bit_idx_q, bit_idx_d;
  logic [1:0]       byte_idx_q, byte_idx_d;

  logic             wr_any, busy, empty, full, push_req, push_ok, pop, clear;
  logic [3:0]       lanes;
  logic [2:0]       wr_nbytes;
  logic [31:0]      merged;
  logic [CRC_W-1:0] result;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  ln);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = ln[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction

  function automatic logic [CRC_W-1:0] bitrev(input logic [CRC_W-1:0] v);
    logic [CRC_W-1:0] r;
    for (int i = 0; i < CRC_W; i++) r[i] = v[CRC_W-1-i];
    return r;
  endfunction

  assign wr_any = (bus.data_write_n != 2'b11);
  assign busy   = (state_q != IDLE);
  assign empty  = (count_q == '0);
  assign full   = (count_q == DEPTH_C);
  assign result = (ctrl_q[REFOUT] ? bitrev(crc_q) : crc_q) ^ (ctrl_q[XOREN] ? xorval_q : '0);

  // Byte-lane enables and push size from the write strobe encoding.
  always_comb begin
    lanes     = 4'b0000;
    wr_nbytes = 3'd4;
    case (bus.data_write_n)
      2'b00:   begin lanes = 4'b0001; wr_nbytes = 3'd1; end
      2'b01:   begin lanes = 4'b0011; wr_nbytes = 3'd2; end
      2'b10:   begin lanes = 4'b1111; wr_nbytes = 3'd4; end
      default: begin lanes = 4'b0000; wr_nbytes = 3'd4; end
    endcase
  end

  // Next-state: register writes, FIFO, FSM and CRC datapath; CLEAR overrides last.
  always_comb begin
    logic [7:0]       cur_byte;
    logic [2:0]       pos;
    logic             b, fb;
    logic [CRC_W-1:0] c;
    logic [31:0]      tmp;

    state_d     = state_q;
    ctrl_d      = ctrl_q;
    ovf_d       = ovf_q;
    done_d      = done_q;
    crc_d       = crc_q;
    poly_d      = poly_q;
    init_d      = init_q;
    xorval_d    = xorval_q;
    fifo_data_d = fifo_data_q;
    fifo_nb_d   = fifo_nb_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    word_d      = word_q;
    nbytes_d    = nbytes_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    push_req    = 1'b0;
    pop         = 1'b0;
    clear       = 1'b0;
    merged      = 32'h0;
    tmp         = 32'h0;

    if (wr_any) begin
      case (bus.address)
        A_CTRL: begin
          ctrl_d = bus.data_in[4:0];
          clear  = bus.data_in[7];
        end
        A_STATUS: begin
          if (bus.data_in[3]) ovf_d  = 1'b0;
          if (bus.data_in[4]) done_d = 1'b0;
        end
        A_DATA: push_req = 1'b1;
        A_POLY: if (!busy) begin
          merged = merge_lanes(32'(poly_q), bus.data_in, lanes);
          poly_d = merged[CRC_W-1:0];
        end
        A_INIT: if (!busy) begin
          merged = merge_lanes(32'(init_q), bus.data_in, lanes);
          init_d = merged[CRC_W-1:0];
        end
        A_XOR: if (!busy) begin
          merged   = merge_lanes(32'(xorval_q), bus.data_in, lanes);
          xorval_d = merged[CRC_W-1:0];
        end
        default: ;
      endcase
    end

    // Byte being shifted; REFIN picks LSB-first, otherwise MSB-first.
    tmp      = word_q >> {byte_idx_q, 3'b000};
    cur_byte = tmp[7:0];
    c        = crc_q;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      pos = bit_idx_q + 3'(k);
      b   = ctrl_q[REFIN] ? cur_byte[pos] : cur_byte[~pos];
      fb  = c[CRC_W-1] ^ b;
      c   = {c[CRC_W-2:0], 1'b0} ^ (fb ? poly_q : '0);
    end

    case (state_q)
      IDLE: if (ctrl_q[EN] && !empty) state_d = FETCH;
      FETCH: begin
        pop        = !empty;
        word_d     = fifo_data_q[rd_ptr_q];
        nbytes_d   = fifo_nb_q[rd_ptr_q];
        byte_idx_d = 2'd0;
        bit_idx_d  = 3'd0;
        state_d    = SHIFT;
      end
      SHIFT: begin
        crc_d     = c;
        bit_idx_d = bit_idx_q + BPC[2:0];
        if (bit_idx_q == LAST_BI) begin
          byte_idx_d = byte_idx_q + 2'd1;
          if ({1'b0, byte_idx_q} + 3'd1 == nbytes_q) begin
            if (ctrl_q[EN] && !empty) state_d = FETCH;
            else begin
              state_d = IDLE;
              if (ctrl_q[EN]) done_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push_req && (!full || pop);
    if (push_req && !push_ok) ovf_d = 1'b1;
    if (push_ok) begin
      fifo_data_d[wr_ptr_q] = bus.data_in;
      fifo_nb_d[wr_ptr_q]   = wr_nbytes;
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d     = count_q + (AW+1)'(push_ok) - (AW+1)'(pop);
    push_prev_d = push_ok;

    if (clear) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      crc_d       = init_q;
      ovf_d       = 1'b0;
      done_d      = 1'b0;
      push_prev_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ctrl_q      <= 5'b01110;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
      push_prev_q <= 1'b0;
      crc_q       <= ONES;
      poly_q      <= POLY_RST[CRC_W-1:0];
      init_q      <= ONES;
      xorval_q    <= ONES;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      word_q      <= 32'h0;
      nbytes_q    <= 3'd0;
      bit_idx_q   <= 3'd0;
      byte_idx_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
      push_prev_q <= push_prev_d;
      crc_q       <= crc_d;
      poly_q      <= poly_d;
      init_q      <= init_d;
      xorval_q    <= xorval_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      word_q      <= word_d;
      nbytes_q    <= nbytes_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
    end
  end

  // FIFO storage; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_nb_q   <= fifo_nb_d;
  end

  // Read mux and RESULT stall.
  always_comb begin
    bus.data_out = 32'h0;
    case (bus.address)
      A_CTRL:   bus.data_out = {27'h0, ctrl_q};
      A_STATUS: bus.data_out = {19'h0, 5'(count_q), 3'b000, done_q, ovf_q, full, empty, busy};
      A_RESULT: bus.data_out = 32'(result);
      A_POLY:   bus.data_out = 32'(poly_q);
      A_INIT:   bus.data_out = 32'(init_q);
      A_XOR:    bus.data_out = 32'(xorval_q);
      default:  bus.data_out = 32'h0;
    endcase
    bus.data_ready = 1'b1;
    if (bus.address == A_RESULT && bus.data_read_n != 2'b11)
      bus.data_ready = empty && !busy && !push_prev_q;
  end

  assign bus.user_interrupt = done_q & ctrl_q[IRQEN];
endmodule

// File: doc/crc_engine_param.md
# crc_engine_param

Parametrised CRC engine peripheral for the TinyQV peripheral bus. It computes CRC-8 to CRC-32 with programmable polynomial, init, reflection and final XOR. Data arrives through a word-wide input FIFO that accepts 1, 2 or 4 bytes per bus write. Throughput is configurable from 1 to 8 bits per clock.

## Interface
Parameters:
- CRC_W, 32: CRC width, 8..32; all CRC registers are masked to CRC_W bits and zero-extended on read.
- FIFO_DEPTH, 4: input FIFO entries, power of 2, 2..16.
- BITS_PER_CYCLE, 1: bits processed per SHIFT cycle; must be 1, 2, 4 or 8.
- POLY_RST, 32'h04C11DB7: POLY reset value, masked to CRC_W.

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- address  in  6  register offset.
- data_in  in  32  write data.
- data_write_n  in  2  11 none, 00 8-bit, 01 16-bit, 10 32-bit.
- data_read_n  in  2  read strobe; it only gates the RESULT stall.
- data_out  out  32  read data, combinational from address.
- data_ready  out  1  read data valid.
- user_interrupt  out  1  level interrupt, DONE & IRQ_EN.

## Operation
Register map. Partial writes update only the written byte lanes.
- 0x00 CTRL:
  - bit0 EN, bit1 REFIN, bit2 REFOUT, bit3 XOREN, bit4 IRQ_EN.
  - bit7 CLEAR: write-only, self-clearing.
  - Reset value 0x0E.
- 0x04 STATUS, read:
  - bit0 BUSY, bit1 EMPTY, bit2 FULL, bit3 OVF (sticky), bit4 DONE (sticky).
  - [12:8] FIFO count.
  - Writing 1 to bit3 or bit4 clears that flag.
- 0x08 DATA, write-only: pushes {data, nbytes}, where nbytes = 1, 2 or 4 from data_write_n. Bytes are consumed LSB-first.
- 0x0C RESULT, read: (REFOUT ? bitreverse_W(crc) : crc) ^ (XOREN ? XORVAL : 0).
- 0x10 POLY (reset POLY_RST), 0x14 INIT (reset all-ones), 0x18 XORVAL (reset all-ones).
  - Writes to these are dropped while BUSY.
  - Other addresses read 0.

CRC step, per input bit b:
- Bit order: MSB-first within the byte, or LSB-first if REFIN.
- fb = crc[CRC_W-1] ^ b; crc = ((crc << 1) ^ (fb ? POLY : 0)) masked to CRC_W.
- crc resets to all-ones.

FSM (IDLE, FETCH, SHIFT):
- IDLE → FETCH when EN and FIFO non-empty.
- FETCH (1 cycle): pop head, latch word and nbytes, byte index = 0.
- SHIFT: 8/BITS_PER_CYCLE cycles per byte. After the last byte:
  - → FETCH if EN and FIFO non-empty;
  - otherwise → IDLE, and set DONE.
- BUSY = (state != IDLE).
- EN cleared mid-run: the current word completes, then the FSM goes to IDLE. DONE is not set.
- DATA writes while EN = 0 are still queued.

FIFO rules:
- Push when full: data dropped, OVF set.
- Push and pop in the same cycle while full: the push is accepted.
- Pop never occurs when empty.

CLEAR:
- Effective the next cycle: state → IDLE, FIFO flushed, crc ← INIT, OVF and DONE cleared.
- CLEAR wins over a simultaneous DATA push.
- The other CTRL bits in the same write are still applied.

Reset mid-operation: all state returns to its reset value next edge. The partial CRC is lost.

## Timing
- Register writes take effect on the next edge.
- A DATA push is visible in STATUS count one cycle later.
- data_ready:
  - RESULT reads: data_ready = 1 only when the FIFO is empty, BUSY = 0 and no push occurred in the previous cycle. Otherwise the read stalls.
  - All other addresses: data_ready = 1 in the same cycle.
- Latency for one word of n bytes: 1 + n·8/BITS_PER_CYCLE cycles from FETCH to IDLE. IDLE → FETCH adds 1 cycle.
- Back-to-back words: FETCH of the next word directly follows the last SHIFT, with no IDLE cycle.
- Reset values of outputs: data_out follows address (RESULT = 0x00000000 with reset config); data_ready 1; user_interrupt 0.
- DONE rises on the edge entering IDLE. user_interrupt follows on the same cycle if IRQ_EN.

## Test plan
- CRC_W=32, reset config, EN=1. Push "123456789" as two 32-bit writes plus one 8-bit write → RESULT 0xCBF43926. Total busy cycles = 3 + 72/BITS_PER_CYCLE.
- CRC_W=16, POLY 0x1021, INIT 0xFFFF, CTRL = EN only (no reflect, no XOR). Push "123456789" bytewise → RESULT 0x29B1.
- CRC_W=8, POLY 0x07, INIT 0x00, XOREN=0, no reflect. Push "123456789" → RESULT 0xF4. Repeat with BITS_PER_CYCLE=1, 2, 4, 8 → identical result.
- FIFO_DEPTH=4, EN=0. Push 5 words → count 4, FULL=1, OVF=1, fifth word lost. Write STATUS 0x08 → OVF=0.
- Mid-run: while BUSY with 2 words queued, write CTRL with CLEAR|EN → next cycle BUSY=0, count 0, RESULT = INIT ^ XORVAL (0x00000000 with defaults).
- IRQ_EN=1: push one byte 0x00 → user_interrupt rises when IDLE is entered. Write STATUS 0x10 → user_interrupt 0 the next cycle. A RESULT read issued during processing holds data_ready=0 until done.
